// File: rtl/key_pkg.sv
// Shared types and constants for the multi-channel key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } hold_state_e;

  // Defaults for a 50 MHz clock: 50 ms debounce, 500 ms to first repeat, 100 ms repeat period.
  localparam int unsigned DEF_N             = 4;
  localparam int unsigned DEF_DELAY         = 2500000;
  localparam int unsigned DEF_REPEAT_START  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5000000;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer_multi_if.sv
// Key-side bundle: raw inputs and repeat enable in, debounced levels and event pulses out.
interface key_debouncer_multi_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] key_in;
  logic         repeat_en;
  logic [N-1:0] key_stable_out;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  logic [N-1:0] key_repeat;

  modport master (
    output key_in, repeat_en,
    input  key_stable_out, key_press, key_release, key_long, key_repeat
  );

  modport slave (
    input  key_in, repeat_en,
    output key_stable_out, key_press, key_release, key_long, key_repeat
  );
endinterface

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce counter, press/release pulses and hold/repeat FSM.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DELAY         = DEF_DELAY,
  parameter int unsigned REPEAT_START  = DEF_REPEAT_START,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_stable,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned CW = cnt_width(DELAY);
  localparam int unsigned HW = cnt_width(max_u(REPEAT_START, REPEAT_PERIOD));
  localparam logic [CW-1:0] CNT_END  = CW'(DELAY);
  localparam logic [HW-1:0] HOLD_END = HW'(REPEAT_START);
  localparam logic [HW-1:0] PER_END  = HW'(REPEAT_PERIOD);

  logic          r_meta, r_sync, r_stable;
  logic [CW-1:0] r_cnt;
  hold_state_e   r_state;
  logic [HW-1:0] r_hcnt;
  logic          r_press, r_release, r_long, r_repeat;

  logic w_mismatch, w_accept, w_rise, w_fall;

  assign w_mismatch = r_sync ^ r_stable;
  assign w_accept   = w_mismatch && (r_cnt == CNT_END);
  assign w_rise     = w_accept && r_sync;
  assign w_fall     = w_accept && !r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Release takes priority over a repeat terminal count on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_hcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      r_repeat  <= 1'b0;
      if (w_fall) begin
        r_state <= StIdle;
        r_hcnt  <= '0;
        r_long  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (w_rise) begin
              r_state <= StHold;
              r_hcnt  <= HW'(1);
            end
          end
          StHold: begin
            if (r_hcnt == HOLD_END) begin
              r_repeat <= i_repeat_en;
              r_long   <= 1'b1;
              r_hcnt   <= HW'(1);
              r_state  <= StRepeat;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
          StRepeat: begin
            if (r_hcnt == PER_END) begin
              r_repeat <= i_repeat_en;
              r_hcnt   <= HW'(1);
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
          default: begin
            r_state <= StIdle;
            r_hcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_debouncer_multi.sv
// N independent debounced key channels sharing one auto-repeat enable.
module key_debouncer_multi
  import key_pkg::*;
#(
  parameter int unsigned N             = DEF_N,
  parameter int unsigned DELAY         = DEF_DELAY,
  parameter int unsigned REPEAT_START  = DEF_REPEAT_START,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic                  clk,
  input logic                  rst,
  key_debouncer_multi_if.slave bus
);

  logic [N-1:0] w_stable, w_press, w_release, w_long, w_repeat;

  for (genvar g = 0; g < N; g++) begin : g_ch
    key_channel #(
      .DELAY         (DELAY),
      .REPEAT_START  (REPEAT_START),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_key       (bus.key_in[g]),
      .i_repeat_en (bus.repeat_en),
      .o_stable    (w_stable[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g]),
      .o_long      (w_long[g]),
      .o_repeat    (w_repeat[g])
    );
  end

  assign bus.key_stable_out = w_stable;
  assign bus.key_press      = w_press;
  assign bus.key_release    = w_release;
  assign bus.key_long       = w_long;
  assign bus.key_repeat     = w_repeat;

endmodule

// File: tb/tb_key_debouncer_multi.sv
// Scoreboard bench: each key hold schedules its expected events, a negedge monitor pops them.
module tb_key_debouncer_multi;

  localparam int unsigned N  = 2;
  localparam int unsigned DL = 4;
  localparam int unsigned RS = 10;
  localparam int unsigned RP = 3;

  typedef enum int {EvPress, EvRelease, EvRepeat, EvLongOn, EvLongOff} ev_e;
  typedef struct {
    int  cyc;
    int  ch;
    ev_e kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_debouncer_multi_if #(.N(N)) bus ();

  key_debouncer_multi #(
    .N             (N),
    .DELAY         (DL),
    .REPEAT_START  (RS),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t          sb_q[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [N-1:0] exp_stable = '0;
  logic [N-1:0] exp_long = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int t, input int ch, input ev_e k);
    ev_t e;
    e.cyc  = t;
    e.ch   = ch;
    e.kind = k;
    sb_q.push_back(e);
  endtask

  task automatic take(input int t, input int ch, input ev_e k, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc == t && sb_q[i].ch == ch && sb_q[i].kind == k) begin
        sb_q.delete(i);
        hit = 1'b1;
        break;
      end
    end
  endtask

  // Key rises at negedge c, falls at negedge r; debounced edges land DL+3 cycles later.
  task automatic plan_hold(input int ch, input int c, input int r, input int en_from);
    int p, rel;
    p   = c + DL + 3;
    rel = r + DL + 3;
    push(p, ch, EvPress);
    push(rel, ch, EvRelease);
    if (p + RS < rel) begin
      push(p + RS, ch, EvLongOn);
      push(rel, ch, EvLongOff);
    end
    for (int t = p + RS; t < rel; t += RP) begin
      if (t >= en_from) push(t, ch, EvRepeat);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      exp_stable = '0;
      exp_long   = '0;
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        bit hp, hr, hk, hon, hoff;
        take(cyc, ch, EvPress, hp);
        take(cyc, ch, EvRelease, hr);
        take(cyc, ch, EvRepeat, hk);
        take(cyc, ch, EvLongOn, hon);
        take(cyc, ch, EvLongOff, hoff);
        if (hp) exp_stable[ch] = 1'b1;
        if (hr) exp_stable[ch] = 1'b0;
        if (hon) exp_long[ch] = 1'b1;
        if (hoff) exp_long[ch] = 1'b0;
        if (hp || bus.key_press[ch])
          check($sformatf("press[%0d]@%0d", ch, cyc), 32'(bus.key_press[ch]), 32'(hp));
        if (hr || bus.key_release[ch])
          check($sformatf("release[%0d]@%0d", ch, cyc), 32'(bus.key_release[ch]), 32'(hr));
        if (hk || bus.key_repeat[ch])
          check($sformatf("repeat[%0d]@%0d", ch, cyc), 32'(bus.key_repeat[ch]), 32'(hk));
        check($sformatf("stable[%0d]@%0d", ch, cyc), 32'(bus.key_stable_out[ch]),
              32'(exp_stable[ch]));
        check($sformatf("long[%0d]@%0d", ch, cyc), 32'(bus.key_long[ch]), 32'(exp_long[ch]));
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stable"}, 32'(bus.key_stable_out), 32'd0);
    check({tag, "_press"}, 32'(bus.key_press), 32'd0);
    check({tag, "_release"}, 32'(bus.key_release), 32'd0);
    check({tag, "_long"}, 32'(bus.key_long), 32'd0);
    check({tag, "_repeat"}, 32'(bus.key_repeat), 32'd0);
  endtask

  task automatic hold(input int ch, input int len, input int en_from);
    plan_hold(ch, cyc, cyc + len, en_from);
    bus.key_in[ch] = 1'b1;
    idle(len);
    bus.key_in[ch] = 1'b0;
  endtask

  initial begin
    int c, d;
    bus.key_in    = '0;
    bus.repeat_en = 1'b1;
    #1 check_all_zero("reset");
    idle(3);
    rst = 1'b1;
    idle(2);

    hold(0, 12, 0);                       // clean press and release
    idle(15);

    bus.key_in[0] = 1'b1;                 // 4-cycle glitch: no events scheduled
    idle(4);
    bus.key_in[0] = 1'b0;
    idle(15);

    hold(0, 5, 0);                        // 5-cycle pulse is accepted
    idle(15);

    c = cyc;                              // both channels in the same cycle
    plan_hold(0, c, c + 8, 0);
    plan_hold(1, c, c + 8, 0);
    bus.key_in = 2'b11;
    idle(8);
    bus.key_in = 2'b00;
    idle(15);

    hold(0, 30, 0);                       // auto-repeat
    idle(15);

    bus.repeat_en = 1'b0;                 // masked repeats, enable raised mid-hold
    c = cyc;
    plan_hold(1, c, c + 30, c + 22);
    bus.key_in[1] = 1'b1;
    idle(21);
    bus.repeat_en = 1'b1;
    idle(9);
    bus.key_in[1] = 1'b0;
    idle(15);

    hold(0, 16, 0);                       // release lands on a repeat terminal
    idle(15);

    c = cyc;                              // async reset mid-repeat with key held
    plan_hold(0, c, c + 1000, 0);
    bus.key_in[0] = 1'b1;
    idle(25);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    idle(3);
    rst = 1'b1;
    d = cyc;
    plan_hold(0, d, d + 20, 0);
    idle(20);
    bus.key_in[0] = 1'b0;
    idle(15);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
